// File: rtl/l2_pipe1_issue_arb.sv
// l2_pipe1_issue_arb
// Issue arbiter and sequencer for L2 pipeline 1. Three requesters (MSHR
// replay, new NoC1 requests, evictions) compete for the single S1 issue slot.
// The block grants at most one per cycle and holds back any request whose set
// index is still in flight in S1..S4. It tracks stage occupancy from the pipe1
// stall signals.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   replay_val/index/rdy             MSHR replay request (highest priority)
//   noc1_val/index/rdy               new NoC1 request (round-robin with evict)
//   evict_val/index/rdy              eviction/flush request (round-robin)
//   stall_S1..stall_S4               pipe1 stage stalls
//   issue_val/src/index              contents of the S1 register
//                                    (src: 0 replay, 1 noc1, 2 evict)
//   inflight_cnt                     number of valid stages among S1..S4
//
// Optional feature: define L2_ISSUE_STARVE_EN to add the starvation counter.
// When the counter is enabled, STARVE_MAX back-to-back replay grants that beat
// a waiting noc1/evict request force one round-robin grant. When the macro is
// not defined, replay has strict priority.
module l2_pipe1_issue_arb #(
  parameter int INDEX_W    = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               replay_val,
  input  logic [INDEX_W-1:0] replay_index,
  output logic               replay_rdy,
  input  logic               noc1_val,
  input  logic [INDEX_W-1:0] noc1_index,
  output logic               noc1_rdy,
  input  logic               evict_val,
  input  logic [INDEX_W-1:0] evict_index,
  output logic               evict_rdy,
  input  logic               stall_S1,
  input  logic               stall_S2,
  input  logic               stall_S3,
  input  logic               stall_S4,
  output logic               issue_val,
  output logic [1:0]         issue_src,
  output logic [INDEX_W-1:0] issue_index,
  output logic [2:0]         inflight_cnt
);

  localparam logic [1:0] SRC_REPLAY = 2'd0;
  localparam logic [1:0] SRC_NOC1   = 2'd1;
  localparam logic [1:0] SRC_EVICT  = 2'd2;

  logic               vld_p1, vld_p2, vld_p3, vld_p4;
  logic [1:0]         src_p1, src_p2, src_p3, src_p4;
  logic [INDEX_W-1:0] idx_p1, idx_p2, idx_p3, idx_p4;
  logic               rr_evict;

  logic               elig_r, elig_n, elig_e;
  logic               grant_en, rr_any, rr_n_win, rr_e_win, starve_ovr;
  logic               gnt_r, gnt_n, gnt_e, gnt_any;
  logic [1:0]         gnt_src;
  logic [INDEX_W-1:0] gnt_idx;

  function automatic logic set_busy(input logic [INDEX_W-1:0]         idx,
                                    input logic [3:0]                 v,
                                    input logic [3:0][INDEX_W-1:0]    tags);
    logic b;
    b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (v[k] && (tags[k] == idx)) b = 1'b1;
    end
    return b;
  endfunction

  // Stages that retire this cycle still block, so the check never needs
  // the stall inputs.
  always_comb begin
    logic [3:0]              v_all;
    logic [3:0][INDEX_W-1:0] t_all;
    v_all  = {vld_p4, vld_p3, vld_p2, vld_p1};
    t_all  = {idx_p4, idx_p3, idx_p2, idx_p1};
    elig_r = replay_val & ~set_busy(replay_index, v_all, t_all);
    elig_n = noc1_val   & ~set_busy(noc1_index,   v_all, t_all);
    elig_e = evict_val  & ~set_busy(evict_index,  v_all, t_all);
  end

`ifdef L2_ISSUE_STARVE_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt;

  function automatic logic [2:0] sat_inc3(input logic [2:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 3'd0;
    end else if (gnt_n || gnt_e) begin
      starve_cnt <= 3'd0;
    end else if (gnt_r && rr_any) begin
      starve_cnt <= sat_inc3(starve_cnt);
    end
  end

  assign starve_ovr = (starve_cnt >= STARVE_LIM);
`else
  assign starve_ovr = 1'b0;
`endif

  // Grants are gated by reset so every rdy reads 0 while rst_n is low.
  assign grant_en = rst_n & ~stall_S1;
  assign rr_any   = elig_n | elig_e;
  assign rr_n_win = elig_n & (~elig_e | ~rr_evict);
  assign rr_e_win = elig_e & (~elig_n |  rr_evict);

  assign gnt_r   = grant_en & elig_r & ~(starve_ovr & rr_any);
  assign gnt_n   = grant_en & rr_n_win & ~gnt_r;
  assign gnt_e   = grant_en & rr_e_win & ~gnt_r;
  assign gnt_any = gnt_r | gnt_n | gnt_e;

  always_comb begin
    gnt_src = SRC_REPLAY;
    gnt_idx = replay_index;
    if (gnt_n) begin
      gnt_src = SRC_NOC1;
      gnt_idx = noc1_index;
    end else if (gnt_e) begin
      gnt_src = SRC_EVICT;
      gnt_idx = evict_index;
    end
  end

  assign replay_rdy = gnt_r;
  assign noc1_rdy   = gnt_n;
  assign evict_rdy  = gnt_e;

  // Stage valids, S1 contents and the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      vld_p3   <= 1'b0;
      vld_p4   <= 1'b0;
      src_p1   <= SRC_REPLAY;
      idx_p1   <= '0;
      rr_evict <= 1'b0;
    end else begin
      if (!stall_S1) begin
        vld_p1 <= gnt_any;
        src_p1 <= gnt_src;
        idx_p1 <= gnt_idx;
      end
      if (!stall_S2) vld_p2 <= vld_p1 & ~stall_S1;
      if (!stall_S3) vld_p3 <= vld_p2 & ~stall_S2;
      if (!stall_S4) vld_p4 <= vld_p3 & ~stall_S3;
      if (gnt_n || gnt_e) rr_evict <= ~rr_evict;
    end
  end

  // S2..S4 tags
  always_ff @(posedge clk) begin
    if (!stall_S2) begin
      src_p2 <= src_p1;
      idx_p2 <= idx_p1;
    end
    if (!stall_S3) begin
      src_p3 <= src_p2;
      idx_p3 <= idx_p2;
    end
    if (!stall_S4) begin
      src_p4 <= src_p3;
      idx_p4 <= idx_p3;
    end
  end

  assign issue_val    = vld_p1;
  assign issue_src    = src_p1;
  assign issue_index  = idx_p1;
  assign inflight_cnt = {2'b00, vld_p1} + {2'b00, vld_p2}
                      + {2'b00, vld_p3} + {2'b00, vld_p4};

endmodule

// File: tb/tb_l2_pipe1_issue_arb.sv
// Testbench for l2_pipe1_issue_arb: directed vectors with hand-computed
// expectations, plus a per-cycle comparison against a behavioural model of
// the pipe occupancy and arbitration rules.
module tb_l2_pipe1_issue_arb;

  localparam int IW   = 8;
  localparam int SMAX = 4;
`ifdef L2_ISSUE_STARVE_EN
  localparam bit STV = 1'b1;
`else
  localparam bit STV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          replay_val = 1'b0, noc1_val = 1'b0, evict_val = 1'b0;
  logic [IW-1:0] replay_index = '0, noc1_index = '0, evict_index = '0;
  logic          replay_rdy, noc1_rdy, evict_rdy;
  logic          stall_S1 = 1'b0, stall_S2 = 1'b0, stall_S3 = 1'b0, stall_S4 = 1'b0;
  logic          issue_val;
  logic [1:0]    issue_src;
  logic [IW-1:0] issue_index;
  logic [2:0]    inflight_cnt;

  always #5 clk = ~clk;

  l2_pipe1_issue_arb #(.INDEX_W(IW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .replay_val(replay_val), .replay_index(replay_index), .replay_rdy(replay_rdy),
    .noc1_val(noc1_val), .noc1_index(noc1_index), .noc1_rdy(noc1_rdy),
    .evict_val(evict_val), .evict_index(evict_index), .evict_rdy(evict_rdy),
    .stall_S1(stall_S1), .stall_S2(stall_S2), .stall_S3(stall_S3), .stall_S4(stall_S4),
    .issue_val(issue_val), .issue_src(issue_src), .issue_index(issue_index),
    .inflight_cnt(inflight_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          v;
    logic [1:0]    src;
    logic [IW-1:0] idx;
  } ent_t;

  ent_t m_st [4];   // m_st[0] is S1 ... m_st[3] is S4
  bit   m_rr_e;     // round-robin favours evict next
  int   m_stv;      // consecutive replay wins over a waiting rr requester

  function automatic bit m_elig(input logic val, input logic [IW-1:0] idx);
    if (!val) return 1'b0;
    foreach (m_st[k]) if (m_st[k].v && m_st[k].idx == idx) return 1'b0;
    return 1'b1;
  endfunction

  // -1 none, 0 replay, 1 noc1, 2 evict
  function automatic int m_grant();
    bit er, en, ee;
    int rrw;
    er = m_elig(replay_val, replay_index);
    en = m_elig(noc1_val, noc1_index);
    ee = m_elig(evict_val, evict_index);
    if (!rst_n || stall_S1) return -1;
    rrw = -1;
    if (en && ee) rrw = m_rr_e ? 2 : 1;
    else if (en)  rrw = 1;
    else if (ee)  rrw = 2;
    if (er && !(STV && m_stv >= SMAX && rrw >= 0)) return 0;
    return rrw;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) m_st[k] <= '0;
      m_rr_e <= 1'b0;
      m_stv  <= 0;
    end else begin
      ent_t          nx [4];
      bit   [3:0]    st;
      int            g;
      logic [IW-1:0] gi;
      g  = m_grant();
      st = {stall_S4, stall_S3, stall_S2, stall_S1};
      nx = m_st;
      for (int k = 1; k < 4; k++) begin
        if (!st[k]) begin
          nx[k]   = m_st[k-1];
          nx[k].v = m_st[k-1].v & !st[k-1];
        end
      end
      gi = (g == 0) ? replay_index : (g == 1) ? noc1_index : evict_index;
      if (!st[0]) begin
        nx[0] = '0;
        if (g >= 0) begin
          nx[0].v   = 1'b1;
          nx[0].src = 2'(g);
          nx[0].idx = gi;
        end
      end
      m_st <= nx;
      if (g == 1 || g == 2) begin
        m_rr_e <= !m_rr_e;
        m_stv  <= 0;
      end else if (g == 0 && (m_elig(noc1_val, noc1_index) || m_elig(evict_val, evict_index))) begin
        m_stv <= (m_stv < 7) ? m_stv + 1 : 7;
      end
    end
  end

  always @(negedge clk) begin
    int g, cnt;
    g   = m_grant();
    cnt = 0;
    for (int k = 0; k < 4; k++) cnt += int'(m_st[k].v);
    chk("model_replay_rdy", replay_rdy, int'(g == 0));
    chk("model_noc1_rdy", noc1_rdy, int'(g == 1));
    chk("model_evict_rdy", evict_rdy, int'(g == 2));
    chk("model_issue_val", issue_val, m_st[0].v);
    if (m_st[0].v) begin
      chk("model_issue_src", issue_src, m_st[0].src);
      chk("model_issue_index", issue_index, m_st[0].idx);
    end
    chk("model_inflight_cnt", inflight_cnt, cnt);
  end

  // ---------------- stimulus ----------------
  int n_r = 0, n_n = 0, n_e = 0;
  int gq[$];

  // One clock cycle; returns at posedge+1 with requesters advanced on transfer.
  task automatic cyc();
    bit fr, fn, fe;
    @(negedge clk);
    fr = replay_val && replay_rdy;
    fn = noc1_val && noc1_rdy;
    fe = evict_val && evict_rdy;
    if (fr) gq.push_back(0);
    if (fn) gq.push_back(1);
    if (fe) gq.push_back(2);
    @(posedge clk);
    #1;
    if (fr) begin
      if (n_r > 1) begin n_r--; replay_index++; end
      else begin n_r = 0; replay_val = 1'b0; end
    end
    if (fn) begin
      if (n_n > 1) begin n_n--; noc1_index++; end
      else begin n_n = 0; noc1_val = 1'b0; end
    end
    if (fe) begin
      if (n_e > 1) begin n_e--; evict_index++; end
      else begin n_e = 0; evict_val = 1'b0; end
    end
  endtask

  task automatic start_r(input logic [IW-1:0] idx, input int n);
    replay_val = 1'b1; replay_index = idx; n_r = n;
  endtask
  task automatic start_n(input logic [IW-1:0] idx, input int n);
    noc1_val = 1'b1; noc1_index = idx; n_n = n;
  endtask
  task automatic start_e(input logic [IW-1:0] idx, input int n);
    evict_val = 1'b1; evict_index = idx; n_e = n;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr [8];
    int exp_sv [10];
    exp_rr = '{1, 2, 1, 2, 1, 2, 1, 2};
`ifdef L2_ISSUE_STARVE_EN
    exp_sv = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
    exp_sv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Reset state, with a request already waiting
    repeat (2) cyc();
    start_n(8'h10, 4);
    #1;
    chk("rst_issue_val", issue_val, 0);
    chk("rst_inflight_cnt", inflight_cnt, 0);
    chk("rst_noc1_rdy", noc1_rdy, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_c0_noc1_rdy", noc1_rdy, 1);
    cyc(); #1;
    chk("idle_c1_issue_val", issue_val, 1);
    chk("idle_c1_issue_src", issue_src, 1);
    chk("idle_c1_issue_index", issue_index, 8'h10);
    chk("idle_c1_cnt", inflight_cnt, 1);
    cyc(); #1;
    chk("idle_c2_cnt", inflight_cnt, 2);
    chk("idle_c2_issue_index", issue_index, 8'h11);
    cyc(); #1;
    chk("idle_c3_cnt", inflight_cnt, 3);
    cyc(); #1;
    chk("idle_c4_cnt", inflight_cnt, 4);
    repeat (4) cyc(); #1;
    chk("idle_c8_cnt", inflight_cnt, 0);

    // Set conflict: same index waits for the entry to leave S4
    start_n(8'h22, 1); #1;
    chk("conf_noc1_rdy", noc1_rdy, 1);
    cyc();
    start_e(8'h22, 1);
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("conf_evict_blocked_c%0d", c), evict_rdy, 0);
      cyc();
    end
    #1;
    chk("conf_evict_free_c5", evict_rdy, 1);
    repeat (7) cyc();

    // Neighbouring index is not blocked
    start_n(8'h22, 1);
    cyc();
    start_e(8'h23, 1); #1;
    chk("adj_evict_rdy", evict_rdy, 1);
    cyc(); #1;
    chk("adj_issue_src", issue_src, 2);
    chk("adj_issue_index", issue_index, 8'h23);
    repeat (6) cyc();

    // Stall propagation: B=0x30 in S3, A=0x31 in S2, then hold three cycles
    start_n(8'h30, 2);
    repeat (3) cyc();
    stall_S1 = 1'b1; stall_S2 = 1'b1; stall_S3 = 1'b1;
    start_e(8'h50, 1);
    for (int c = 3; c <= 5; c++) begin
      #1;
      chk($sformatf("stall_c%0d_cnt", c), inflight_cnt, 2);
      chk($sformatf("stall_c%0d_evict_rdy", c), evict_rdy, 0);
      cyc();
    end
    stall_S1 = 1'b0; stall_S2 = 1'b0; stall_S3 = 1'b0;
    #1;
    chk("stall_c6_cnt", inflight_cnt, 2);
    chk("stall_c6_evict_rdy", evict_rdy, 1);
    cyc(); #1;
    chk("stall_c7_cnt", inflight_cnt, 3);
    cyc(); #1;
    chk("stall_c8_cnt", inflight_cnt, 2);
    cyc(); #1;
    chk("stall_c9_cnt", inflight_cnt, 1);
    cyc(); #1;
    chk("stall_c10_cnt", inflight_cnt, 1);
    cyc(); #1;
    chk("stall_c11_cnt", inflight_cnt, 0);

    // Round robin between noc1 and evict, starting with noc1 after reset
    do_reset();
    gq.delete();
    start_n(8'h20, 4);
    start_e(8'h60, 4);
    repeat (10) cyc();
    chk("rr_grant_count", gq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr_grant%0d_src", i), (i < gq.size()) ? gq[i] : -1, exp_rr[i]);

    // Replay against a continuously waiting noc1
    do_reset();
    gq.delete();
    start_r(8'h40, 10);
    start_n(8'h80, 10);
    repeat (10) cyc();
    chk("starve_grant_count", gq.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_grant%0d_src", i), (i < gq.size()) ? gq[i] : -1, exp_sv[i]);
    replay_val = 1'b0; noc1_val = 1'b0; n_r = 0; n_n = 0;

    // Asynchronous reset with three stages valid; pointer is on evict before it
    do_reset();
    start_n(8'h90, 3);
    repeat (3) cyc();
    #1;
    chk("arst_pre_cnt", inflight_cnt, 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_issue_val", issue_val, 0);
    chk("arst_cnt", inflight_cnt, 0);
    cyc();
    rst_n = 1'b1;
    start_n(8'hA0, 1);
    start_e(8'hB0, 1);
    #1;
    chk("arst_first_noc1_rdy", noc1_rdy, 1);
    chk("arst_first_evict_rdy", evict_rdy, 0);
    cyc(); #1;
    chk("arst_first_issue_src", issue_src, 1);
    chk("arst_first_issue_index", issue_index, 8'hA0);
    repeat (6) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
